// File: rtl/cdc_ctrl_pkg.sv
// Shared types and defaults for the 4-phase req/ack CDC receive controller.
//   state_t          : controller FSM encoding (IDLE, HOLD, ACK, ERR)
//   DEF_SYNC_STAGES  : default depth of the request synchroniser chain
package cdc_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // waiting for a synchronised request
    HOLD = 2'd1,  // word presented to the consumer
    ACK  = 2'd2,  // ack raised, waiting for the source to drop req
    ERR  = 2'd3   // source never dropped req; parked until reset
  } state_t;

  localparam int DEF_SYNC_STAGES = 2;

endpackage

// File: rtl/req_sync_stages.sv
// Multi-flop synchroniser for the asynchronous request level.
//   dst_clk   in  destination clock
//   rst       in  synchronous active-high reset, clears the whole chain
//   async_req in  request level from the source domain
//   req_s     out request after SYNC_STAGES dst_clk flops
import cdc_ctrl_pkg::*;

module req_sync_stages #(
  parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
  input  logic dst_clk,
  input  logic rst,
  input  logic async_req,
  output logic req_s
);

  logic [SYNC_STAGES-1:0] sync_ff;

  always_ff @(posedge dst_clk) begin
    if (rst) sync_ff <= '0;
    else     sync_ff <= {sync_ff[SYNC_STAGES-2:0], async_req};
  end

  assign req_s = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/hs_cdc_rx_ctrl.sv
// Destination-side controller for a 4-phase req/ack clock-domain crossing.
// The request is synchronised; the data bus is sampled raw, which is safe
// because the source holds it stable for as long as req is high.
// The captured word is offered on a valid/ready port, then ack is raised
// and held until the synchronised request drops.
//
// Optional feature macro: TIMEOUT_EN
//   defined   : ack phase is bounded by TIMEOUT_CYCLES; overrun sets sticky err
//               and parks the FSM in ERR until rst.
//   undefined : ack waits indefinitely, err is constant 0.
//
// Ports
//   dst_clk    in  clock, all logic on the rising edge
//   rst        in  synchronous active-high reset
//   async_req  in  source request level (asynchronous)
//   async_data in  source data, stable while async_req=1
//   data_ready in  consumer accept
//   data_out   out captured word (registered)
//   data_valid out data_out valid (registered)
//   ack        out level ack to source (registered)
//   busy       out FSM not in IDLE
//   err        out sticky timeout flag
import cdc_ctrl_pkg::*;

module hs_cdc_rx_ctrl #(
  parameter int DATA_W         = 8,
  parameter int SYNC_STAGES    = DEF_SYNC_STAGES,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              dst_clk,
  input  logic              rst,
  input  logic              async_req,
  input  logic [DATA_W-1:0] async_data,
  input  logic              data_ready,
  output logic [DATA_W-1:0] data_out,
  output logic              data_valid,
  output logic              ack,
  output logic              busy,
  output logic              err
);

  // Elaboration-time sanity on the configuration.
  if (SYNC_STAGES < 2 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("hs_cdc_rx_ctrl: SYNC_STAGES must be >= 2 and TIMEOUT_CYCLES >= 1");
  end

  logic req_s;

  req_sync_stages #(.SYNC_STAGES(SYNC_STAGES)) u_req_sync (
    .dst_clk   (dst_clk),
    .rst       (rst),
    .async_req (async_req),
    .req_s     (req_s)
  );

  state_t            state, state_n;
  logic [DATA_W-1:0] data_out_n;
  logic              data_valid_n, ack_n, err_n;

`ifdef TIMEOUT_EN
  localparam int              CNT_W   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYCLES);
  logic [CNT_W-1:0] to_cnt, to_cnt_n;
`endif

  always_ff @(posedge dst_clk) begin
    if (rst) begin
      state      <= IDLE;
      data_out   <= '0;
      data_valid <= 1'b0;
      ack        <= 1'b0;
      err        <= 1'b0;
`ifdef TIMEOUT_EN
      to_cnt     <= '0;
`endif
    end else begin
      state      <= state_n;
      data_out   <= data_out_n;
      data_valid <= data_valid_n;
      ack        <= ack_n;
      err        <= err_n;
`ifdef TIMEOUT_EN
      to_cnt     <= to_cnt_n;
`endif
    end
  end

  always_comb begin
    state_n      = state;
    data_out_n   = data_out;
    data_valid_n = data_valid;
    ack_n        = ack;
    err_n        = err;
`ifdef TIMEOUT_EN
    to_cnt_n     = to_cnt;
`endif
    case (state)
      IDLE: begin
        if (req_s) begin
          data_out_n   = async_data;
          data_valid_n = 1'b1;
          state_n      = HOLD;
        end
      end
      // req_s dropping here is a source protocol violation; keep offering
      // the word rather than losing it.
      HOLD: begin
        if (data_ready) begin
          data_valid_n = 1'b0;
          ack_n        = 1'b1;
          state_n      = ACK;
`ifdef TIMEOUT_EN
          to_cnt_n     = '0;
`endif
        end
      end
      ACK: begin
        if (!req_s) begin
          ack_n   = 1'b0;
          state_n = IDLE;
        end
`ifdef TIMEOUT_EN
        else if (to_cnt == TO_LAST) begin
          err_n   = 1'b1;
          ack_n   = 1'b0;
          state_n = ERR;
        end else begin
          to_cnt_n = to_cnt + 1'b1;
        end
`endif
      end
      ERR: begin
        // Terminal until rst; all inputs ignored.
        ack_n        = 1'b0;
        data_valid_n = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_hs_cdc_rx_ctrl.sv
// Self-checking bench for hs_cdc_rx_ctrl: directed protocol steps followed
// by a randomised well-behaved source with random consumer back-pressure and
// occasional resets. A cycle-level reference model tracks expected outputs.
module tb_hs_cdc_rx_ctrl;

  localparam int DW = 8;
  localparam int S  = 2;
  localparam int TO = 8;

  logic          dst_clk = 1'b0;
  logic          rst, async_req, data_ready;
  logic [DW-1:0] async_data;
  logic [DW-1:0] data_out;
  logic          data_valid, ack, busy, err;

  hs_cdc_rx_ctrl #(.DATA_W(DW), .SYNC_STAGES(S), .TIMEOUT_CYCLES(TO)) dut (
    .dst_clk    (dst_clk),
    .rst        (rst),
    .async_req  (async_req),
    .async_data (async_data),
    .data_ready (data_ready),
    .data_out   (data_out),
    .data_valid (data_valid),
    .ack        (ack),
    .busy       (busy),
    .err        (err)
  );

  always #5 dst_clk = ~dst_clk;

  int checks = 0;
  int errors = 0;

  // Reference model: request history as a delay line of raw samples, plus
  // protocol flags for "word offered", "ack raised", "timed out".
  bit          req_hist[$];
  logic [DW-1:0] m_dout;
  bit          m_valid, m_ack, m_err;
  int          m_ack_cycles;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    req_hist.delete();
    for (int i = 0; i < S; i++) req_hist.push_back(1'b0);
    m_dout = '0; m_valid = 0; m_ack = 0; m_err = 0; m_ack_cycles = 0;
  endtask

  task automatic model_edge();
    bit r;
    if (rst) begin
      model_clear();
    end else begin
      // request as seen by the controller: sampled S edges ago
      r = req_hist.pop_front();
      req_hist.push_back(async_req);
      if (m_err) begin
        // parked
      end else if (m_ack) begin
        if (!r) m_ack = 0;
`ifdef TIMEOUT_EN
        else if (m_ack_cycles == TO) begin m_err = 1; m_ack = 0; end
`endif
        else m_ack_cycles++;
      end else if (m_valid) begin
        if (data_ready) begin m_valid = 0; m_ack = 1; m_ack_cycles = 0; end
      end else if (r) begin
        m_dout = async_data; m_valid = 1;
      end
    end
  endtask

  task automatic compare_all();
    chk("data_out",   data_out,   m_dout);
    chk("data_valid", data_valid, m_valid);
    chk("ack",        ack,        m_ack);
    chk("busy",       busy,       m_valid | m_ack | m_err);
    chk("err",        err,        m_err);
    chk("valid_ack_excl", data_valid & ack, 1'b0);
  endtask

  task automatic step();
    @(posedge dst_clk);
    model_edge();
    @(negedge dst_clk);
    compare_all();
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (ack !== lvl && n < 20) begin step(); n++; end
    chk(tag, ack, lvl);
  endtask

  initial begin
    int n_xfer;
    logic [DW-1:0] last_word;
    int src_ph, dly;

    model_clear();
    rst = 1; async_req = 1; async_data = 8'h11; data_ready = 0;
    @(negedge dst_clk);

    // 1: reset with req high, then capture latency after release
    step(); step();
    chk("rst_valid", data_valid, 1'b0);
    chk("rst_ack",   ack,        1'b0);
    chk("rst_dout",  data_out,   8'h00);
    rst = 0;
    for (int i = 1; i <= S + 1; i++) begin
      step();
      if (i == S)     chk("lat_not_yet", data_valid, 1'b0);
      if (i == S + 1) chk("lat_valid",   data_valid, 1'b1);
    end
    data_ready = 1; step();
    async_req = 0; data_ready = 0;
    wait_ack(1'b0, "t1_ack_fall");

    // 2: A5 with ready high
    async_data = 8'hA5; async_req = 1; data_ready = 1;
    for (int i = 0; i < S + 1; i++) step();
    chk("t2_valid", data_valid, 1'b1);
    chk("t2_dout",  data_out,   8'hA5);
    step();
    chk("t2_valid_pulse", data_valid, 1'b0);
    chk("t2_ack_rise",    ack,        1'b1);
    async_req = 0; data_ready = 0;
    for (int i = 0; i < S + 1; i++) step();
    chk("t2_ack_fall", ack, 1'b0);

    // 3: back-pressure for 5 cycles
    async_req = 1;
    for (int i = 0; i < S + 1; i++) step();
    for (int i = 0; i < 5; i++) begin
      step();
      chk("t3_hold_valid", data_valid, 1'b1);
      chk("t3_hold_dout",  data_out,   8'hA5);
      chk("t3_hold_ack",   ack,        1'b0);
    end
    data_ready = 1; step();
    chk("t3_ack", ack, 1'b1);

    // 4: re-raise with 3C right after ack falls
    async_req = 0; data_ready = 0;
    wait_ack(1'b0, "t4_ack_fall");
    async_data = 8'h3C; async_req = 1; data_ready = 1;
    n_xfer = 0; last_word = '0;
    for (int i = 0; i < 14; i++) begin
      if (ack) async_req = 0;
      if (data_valid && data_ready) begin n_xfer++; last_word = data_out; end
      step();
    end
    chk("t4_xfer_count", n_xfer, 1);
    chk("t4_xfer_word",  last_word, 8'h3C);

    // 6: reset while in ACK with req still high, then recapture
    async_data = 8'h5A; async_req = 1; data_ready = 1;
    wait_ack(1'b1, "t6_ack_rise");
    rst = 1; data_ready = 0; step();
    chk("t6_rst_ack",  ack,  1'b0);
    chk("t6_rst_busy", busy, 1'b0);
    rst = 0;
    for (int i = 0; i < S + 1; i++) step();
    chk("t6_recap_valid", data_valid, 1'b1);
    chk("t6_recap_dout",  data_out,   8'h5A);
    data_ready = 1; step();
    chk("t6_ack", ack, 1'b1);

    // 5: source holds req after ack
    data_ready = 0;
    for (int i = 0; i < 15; i++) step();
`ifdef TIMEOUT_EN
    chk("t5_err", err, 1'b1);
    chk("t5_ack", ack, 1'b0);
    chk("t5_busy", busy, 1'b1);
    async_data = 8'hFF; data_ready = 1; async_req = 0;
    for (int i = 0; i < 6; i++) step();
    chk("t5_err_sticky", err, 1'b1);
`else
    chk("t5_ack_held", ack, 1'b1);
    chk("t5_no_err",   err, 1'b0);
`endif
    rst = 1; async_req = 0; data_ready = 0; step();
    rst = 0; step();
    chk("t5_err_clear", err, 1'b0);

    // Randomised phase: 4-phase source, random ready, rare resets
    src_ph = 0; dly = 0;
    for (int c = 0; c < 800; c++) begin
      data_ready = ($urandom_range(0, 2) != 0);
      rst = ($urandom_range(0, 149) == 0);
      case (src_ph)
        0: if (dly == 0) begin
             async_req = 1; async_data = DW'($urandom); src_ph = 1;
           end else dly--;
        1: if (ack) begin async_req = 0; src_ph = 2; end
        default: if (!ack) begin src_ph = 0; dly = $urandom_range(0, 4); end
      endcase
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
